bidir_link_arb: RTL and testbench



---
 rtl/bidir_link_pkg.sv | 15 +
 rtl/bidir_turn_timer.sv | 32 +++
 rtl/bidir_link_arb.sv | 121 ++++++++++++
 tb/tb_bidir_link_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bidir_link_pkg.sv
// Shared definitions for the bidirectional link controller.
// State encoding and buffer direction codes.
package bidir_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRV_A = 2'd2,
    ST_DRV_B = 2'd3
  } state_t;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

endpackage

// File: rtl/bidir_turn_timer.sv
// Loadable down-counter for link turnaround gaps.
// done is high in the last cycle of a loaded interval.
module bidir_turn_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         run;

  // count down from the loaded value, stop once zero is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/bidir_link_arb.sv
// Arbiter for the shared bidirectional buffer.
// Grants one side at a time with dead cycles on every flip.
module bidir_link_arb
  import bidir_link_pkg::*;
#(
  parameter int unsigned TURN_CYC  = 2,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic oe,
  output logic busy
);

  localparam logic [3:0] TURN_LD =
    4'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] BURST_LAST =
    CNT_W'(MAX_BURST - 1);

  state_t           state, state_nxt;
  logic             sel_nxt;
  logic             last_owner, owner_nxt;
  logic [CNT_W-1:0] burst, burst_nxt;
  logic             turn_load, turn_done;
  logic             win, own_req, oth_req;

  bidir_turn_timer #(.W(4)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (turn_load),
    .load_val (TURN_LD),
    .done     (turn_done)
  );

  // state, direction, ownership and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= DIR_B2A;
      last_owner <= DIR_B2A;
      burst      <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      oe         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_owner <= owner_nxt;
      burst      <= burst_nxt;
      gnt_a      <= (state_nxt == ST_DRV_A);
      gnt_b      <= (state_nxt == ST_DRV_B);
      oe         <= (state_nxt == ST_DRV_A) ||
                    (state_nxt == ST_DRV_B);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // arbitration, turnaround and burst limiting
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    owner_nxt = last_owner;
    burst_nxt = burst;
    turn_load = 1'b0;
    win       = DIR_B2A;
    own_req   = 1'b0;
    oth_req   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        burst_nxt = '0;
        if (req_a || req_b) begin
          win = (req_a && req_b) ? ~last_owner
                                 : req_a;
          if (win == sel) begin
            state_nxt = (win == DIR_A2B) ? ST_DRV_A
                                         : ST_DRV_B;
          end else begin
            sel_nxt   = win;
            turn_load = 1'b1;
            state_nxt = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        if (turn_done) begin
          if (sel == DIR_A2B)
            state_nxt = req_a ? ST_DRV_A : ST_IDLE;
          else
            state_nxt = req_b ? ST_DRV_B : ST_IDLE;
        end
      end
      ST_DRV_A, ST_DRV_B: begin
        own_req   = (state == ST_DRV_A) ? req_a : req_b;
        oth_req   = (state == ST_DRV_A) ? req_b : req_a;
        burst_nxt = burst + 1'b1;
        if (!own_req || burst == BURST_LAST) begin
          burst_nxt = '0;
          if (!own_req || oth_req) begin
            owner_nxt = sel;
            if (oth_req) begin
              sel_nxt   = ~sel;
              turn_load = 1'b1;
              state_nxt = ST_TURN;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bidir_link_arb.sv
// Directed bench for the bidirectional link arbiter.
// Output vector is {gnt_a, gnt_b, sel, oe, busy}.
module tb_bidir_link_arb;

  logic clk = 1'b0;
  logic rst;
  logic req_a;
  logic req_b;
  logic gnt_a, gnt_b, sel, oe, busy;
  logic [4:0] o;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] P_RST    = 5'b00000;
  localparam logic [4:0] P_IDLE_B = 5'b00000;
  localparam logic [4:0] P_IDLE_A = 5'b00100;
  localparam logic [4:0] P_TURN_A = 5'b00101;
  localparam logic [4:0] P_TURN_B = 5'b00001;
  localparam logic [4:0] P_DRV_A  = 5'b10111;
  localparam logic [4:0] P_DRV_B  = 5'b01011;

  bidir_link_arb #(
    .TURN_CYC  (2),
    .MAX_BURST (8),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .sel   (sel),
    .oe    (oe),
    .busy  (busy)
  );

  assign o = {gnt_a, gnt_b, sel, oe, busy};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [4:0] exp);
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, o, exp);
    end
  endtask

  task automatic chk_bit(input string tag,
                         input logic obs,
                         input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] exp;
    logic       prev_sel;
    int         p;

    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;

    // reset then idle
    step();
    chk("rst_c1", P_RST);
    step();
    chk("rst_c2", P_RST);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", P_IDLE_B);
    end

    // same-direction fast path, burst beyond MAX_BURST
    req_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("fast_b", P_DRV_B);
    end
    req_b = 1'b0;
    step();
    chk("rel_b", P_IDLE_B);

    // turnaround to A, then preemption by B
    req_a = 1'b1;
    step();
    chk("turn_a_c1", P_TURN_A);
    step();
    chk("turn_a_c2", P_TURN_A);
    step();
    chk("gnt_a_c3", P_DRV_A);
    step();
    chk("gnt_a_c4", P_DRV_A);
    req_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("burst_a", P_DRV_A);
    end
    step();
    chk("pre_turn_b1", P_TURN_B);
    step();
    chk("pre_turn_b2", P_TURN_B);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("burst_b", P_DRV_B);
    end
    step();
    chk("pre_turn_a1", P_TURN_A);
    step();
    chk("pre_turn_a2", P_TURN_A);
    step();
    chk("back_to_a", P_DRV_A);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("rel_both", P_IDLE_A);

    // tie out of reset, continuous fairness
    rst = 1'b1;
    step();
    step();
    chk("rst_tie", P_RST);
    rst = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    prev_sel = 1'b0;
    for (int i = 1; i <= 44; i++) begin
      step();
      p = (i - 1) % 20;
      if (p < 2)       exp = P_TURN_A;
      else if (p < 10) exp = P_DRV_A;
      else if (p < 12) exp = P_TURN_B;
      else             exp = P_DRV_B;
      chk("tie_seq", exp);
      chk_bit("gnt_excl", gnt_a & gnt_b, 1'b0);
      if (oe) chk_bit("sel_stable", sel, prev_sel);
      prev_sel = sel;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("tie_rel", P_IDLE_A);

    // abort during turnaround
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req_a = 1'b1;
    step();
    chk("ab_turn_a1", P_TURN_A);
    step();
    chk("ab_turn_a2", P_TURN_A);
    step();
    chk("ab_gnt_a", P_DRV_A);
    req_a = 1'b0;
    step();
    chk("ab_idle_a", P_IDLE_A);
    req_b = 1'b1;
    step();
    chk("ab_turn_b1", P_TURN_B);
    req_b = 1'b0;
    step();
    chk("ab_turn_b2", P_TURN_B);
    step();
    chk("ab_no_gnt", P_IDLE_B);
    step();
    chk("ab_stay", P_IDLE_B);

    // reset in the middle of an A grant
    req_a = 1'b1;
    step();
    chk("rd_turn1", P_TURN_A);
    step();
    chk("rd_turn2", P_TURN_A);
    step();
    chk("rd_gnt1", P_DRV_A);
    step();
    chk("rd_gnt2", P_DRV_A);
    rst = 1'b1;
    step();
    chk("rd_reset", P_RST);
    rst = 1'b0;
    step();
    chk("rd_reacq", P_TURN_A);
    req_a = 1'b0;
    step();
    chk("rd_turn_b", P_TURN_A);
    step();
    chk("rd_idle", P_IDLE_A);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
